// File: rtl/preg_free_list.sv
// Circular FIFO of free physical register indices between commit (push) and rename (pop).
// P0 backs x0 permanently: it is never handed out and returns of it are ignored.
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH     = NUM_PREGS - ARCH_REGS,
  parameter int PW        = $clog2(NUM_PREGS),
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_ready,
  output logic [PW-1:0] alloc_preg,
  input  logic          free_valid,
  input  logic [PW-1:0] free_preg,
  output logic [CW-1:0] free_count,
  output logic          overflow_err,
  output logic          underflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] entry_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full, empty, pop, eligible, push;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = alloc_req && !empty;
  assign eligible = free_valid && (free_preg != '0);
  // A full list still accepts a return when a pop frees a slot in the same cycle.
  assign push     = eligible && (!full || pop);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    overflow_d  = overflow_q  || (eligible && full && !pop);
    underflow_d = underflow_q || (alloc_req && empty);
    if (pop)
      head_d = (head_q == AW'(DEPTH - 1)) ? '0 : head_q + AW'(1);
    if (push)
      tail_d = (tail_q == AW'(DEPTH - 1)) ? '0 : tail_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= CW'(DEPTH);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Each slot reloads its reset-time index so the list starts holding P(ARCH_REGS)..P(NUM_PREGS-1).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst)
        entry_q[gi] <= PW'(ARCH_REGS + gi);
      else if (push && (tail_q == AW'(gi)))
        entry_q[gi] <= free_preg;
    end
  end

  assign alloc_ready   = !empty;
  assign alloc_preg    = entry_q[head_q];
  assign free_count    = count_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: hand-computed expectations plus a small FIFO model for the wrap test.
module tb_preg_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_ready;
  logic [5:0] alloc_preg;
  logic       free_valid;
  logic [5:0] free_preg;
  logic [5:0] free_count;
  logic       overflow_err;
  logic       underflow_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int q_model[$];

  preg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_preg   (alloc_preg),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .free_count   (free_count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %s: observed %0d expected %0d", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_preg = '0;
    step();
    rst = 1'b0;

    // 1: reset state and three pops
    chk("rst_ready", alloc_ready, 1);
    chk("rst_preg", alloc_preg, 32);
    chk("rst_count", free_count, 32);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_unf", underflow_err, 0);
    alloc_req = 1'b1;
    step();
    chk("t1_preg1", alloc_preg, 33);
    chk("t1_count1", free_count, 31);
    step();
    chk("t1_preg2", alloc_preg, 34);
    chk("t1_count2", free_count, 30);
    step();
    alloc_req = 1'b0;
    chk("t1_count3", free_count, 29);
    chk("t1_ready", alloc_ready, 1);

    // 2: drain the rest, then underflow
    for (int i = 0; i < 29; i++) begin
      chk("t2_drain", alloc_preg, 35 + i);
      alloc_req = 1'b1;
      step();
    end
    alloc_req = 1'b0;
    chk("t2_ready", alloc_ready, 0);
    chk("t2_count", free_count, 0);
    chk("t2_unf0", underflow_err, 0);
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    chk("t2_unf1", underflow_err, 1);
    chk("t2_count_hold", free_count, 0);

    // 3: push P5, P7 into the empty list, then pop both
    free_valid = 1'b1; free_preg = 6'd5;
    step();
    chk("t3_ready", alloc_ready, 1);
    chk("t3_preg5", alloc_preg, 5);
    chk("t3_count1", free_count, 1);
    free_preg = 6'd7;
    step();
    free_valid = 1'b0;
    chk("t3_count2", free_count, 2);
    alloc_req = 1'b1;
    chk("t3_pop5", alloc_preg, 5);
    step();
    chk("t3_pop7", alloc_preg, 7);
    step();
    alloc_req = 1'b0;
    chk("t3_empty", alloc_ready, 0);
    chk("t3_count0", free_count, 0);

    // 4: returning P0 to a full list is a silent no-op
    rst = 1'b1;
    step();
    rst = 1'b0;
    free_valid = 1'b1; free_preg = 6'd0;
    step();
    free_valid = 1'b0;
    chk("t4_count", free_count, 32);
    chk("t4_ovf", overflow_err, 0);
    chk("t4_unf", underflow_err, 0);

    // 5: overflow on full, then push+pop on full
    free_valid = 1'b1; free_preg = 6'd9;
    step();
    chk("t5_ovf", overflow_err, 1);
    chk("t5_count", free_count, 32);
    chk("t5_head", alloc_preg, 32);
    alloc_req = 1'b1;
    chk("t5_pop32", alloc_preg, 32);
    step();
    alloc_req = 1'b0; free_valid = 1'b0;
    chk("t5_count_pp", free_count, 32);
    chk("t5_next", alloc_preg, 33);
    chk("t5_unf", underflow_err, 0);

    // 6: model now holds P33..P63 followed by P9
    for (int i = 33; i < 64; i++) q_model.push_back(i);
    q_model.push_back(9);
    for (int i = 0; i < 10; i++) begin
      alloc_req = 1'b1;
      chk("t6_pop", alloc_preg, q_model[0]);
      step();
      void'(q_model.pop_front());
    end
    alloc_req = 1'b0;
    chk("t6_count22", free_count, 22);
    for (int i = 0; i < 40; i++) begin
      alloc_req = 1'b1; free_valid = 1'b1; free_preg = 6'((i % 10) + 1);
      chk("t6_wrap", alloc_preg, q_model[0]);
      step();
      void'(q_model.pop_front());
      q_model.push_back((i % 10) + 1);
    end
    chk("t6_count_wrap", free_count, 22);
    chk("t6_ovf_sticky", overflow_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; alloc_req = 1'b0; free_valid = 1'b0;
    chk("t6_rst_preg", alloc_preg, 32);
    chk("t6_rst_count", free_count, 32);
    chk("t6_rst_ready", alloc_ready, 1);
    chk("t6_rst_ovf", overflow_err, 0);
    chk("t6_rst_unf", underflow_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Circular FIFO of free physical register indices.
- Sits between commit, which is downstream of the ROB, and the rename stage.
- Rename pops one new PRD per renamed instruction that writes a register.
- Commit pushes the committed instruction's old PRD back onto the list.
- P0 is hard-wired to x0. It is never allocated and never returned to the list.

Parameters:
- NUM_PREGS, 64, total physical registers; must be a power of two and greater than ARCH_REGS.
- ARCH_REGS, 32, architectural registers. Pi backs xi at reset for i in 0..ARCH_REGS-1.
- DEPTH, NUM_PREGS-ARCH_REGS, free list capacity (32).
- PW, $clog2(NUM_PREGS), width of a physical register index.
- CW, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  1  rename requests one free PRD this cycle.
- alloc_ready  out  1  list non-empty; a PRD is available.
- alloc_preg  out  PW  PRD at the head; valid when alloc_ready=1.
- free_valid  in  1  commit returns a PRD this cycle.
- free_preg  in  PW  PRD being returned (commit_old_preg).
- free_count  out  CW  number of entries currently free.
- overflow_err  out  1  sticky flag: a push was attempted while the list was full.
- underflow_err  out  1  sticky flag: alloc_req was asserted while alloc_ready=0.

Behaviour:
- Storage: DEPTH x PW array, head pointer, tail pointer (both $clog2(DEPTH) bits), count register (CW bits).
- Reset (synchronous, rst=1 at the edge):
  - entry[i] = ARCH_REGS+i for i in 0..DEPTH-1.
  - head=0, tail=0, count=DEPTH.
  - overflow_err=0, underflow_err=0.
  - After reset: alloc_ready=1, alloc_preg=ARCH_REGS (P32), free_count=DEPTH.
- rst has priority over every other input in the same cycle.
- A reset asserted mid-operation discards all in-flight state and reinitialises exactly as above.
- alloc_ready = (count != 0). alloc_preg = entry[head]. Both are combinational from registered state.
- Pop: fires when alloc_req && alloc_ready.
  - Effect: head <= head+1, wrapping modulo DEPTH.
  - Rename consumes alloc_preg in the same cycle.
  - Zero-cycle latency, so back-to-back pops every cycle are supported.
- Underflow: alloc_req && !alloc_ready.
  - No state change except underflow_err <= 1.
- Push eligibility:
  - A push is eligible when free_valid && free_preg != 0.
  - free_valid with free_preg == 0 is a no-op; this is the store/branch commit case and must not raise an error.
- Push: an eligible push with count < DEPTH, or with count == DEPTH and a pop in the same cycle.
  - entry[tail] <= free_preg; tail <= tail+1, wrapping modulo DEPTH.
- Overflow: an eligible push with count == DEPTH and no pop this cycle.
  - No state change except overflow_err <= 1.
- Count update: count <= count + push - pop. A simultaneous pop and push leaves count unchanged.
- No same-cycle bypass. A PRD pushed in cycle N is poppable in cycle N+1 at the earliest.
  - With count==0, a push plus alloc_req in the same cycle: the push lands and underflow_err sets. The PRD is available the next cycle.
- Wrap-around: head and tail wrap independently. Full vs empty is resolved by count only, never by pointer equality.
- Sticky error flags clear only on reset.
- No mispredict or flush recovery port in this revision. Free-list checkpointing is a separate block.

Test Plan:
1. Reset, then alloc_req=1 for 3 cycles -> alloc_preg P32, P33, P34 on successive cycles; free_count 32->29; alloc_ready stays 1.
2. Drain with 32 consecutive pops -> alloc_ready=0 after the 32nd; free_count=0. An extra alloc_req sets underflow_err=1, and head is unchanged.
3. From empty, push P5, then P7 on the next cycle -> alloc_preg=P5 and alloc_ready=1 one cycle after the first push; pops return P5 then P7.
4. free_valid=1 with free_preg=0 -> free_count unchanged, no error flags (store/branch commit).
5. Full list (count=32): free_valid with P9 -> overflow_err=1, count stays 32. Repeat with alloc_req=1 in the same cycle -> pop returns P32, P9 is written at the tail, count stays 32, no new error.
6. Pop 10 entries, push P1..P10 with pops every cycle for 40 cycles (wrap) -> FIFO order preserved; then assert rst mid-stream -> next cycle alloc_preg=P32, free_count=32, both error flags cleared.
